// File: rtl/ddr3_mem_array.sv
// Dual-port backing store for the DDR3 model: field-extracted index, byte-masked writes,
// write-first collisions and a RD_LATENCY-deep read pipeline. Optional macro: MEM_UNINIT_CHK_EN.
module ddr3_mem_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 36,
  parameter int BANK_W     = 3,
  parameter int BANK_LSB   = 32,
  parameter int ROW_W      = 5,
  parameter int ROW_LSB    = 16,
  parameter int COL_W      = 8,
  parameter int COL_LSB    = 0,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_uninit
);

  localparam int IW    = BANK_W + ROW_W + COL_W;
  localparam int DEPTH = 1 << IW;
  localparam int NB    = DATA_WIDTH / 8;

  localparam bit OVL_BR = (BANK_LSB < ROW_LSB + ROW_W) && (ROW_LSB < BANK_LSB + BANK_W);
  localparam bit OVL_BC = (BANK_LSB < COL_LSB + COL_W) && (COL_LSB < BANK_LSB + BANK_W);
  localparam bit OVL_RC = (ROW_LSB < COL_LSB + COL_W) && (COL_LSB < ROW_LSB + ROW_W);

  if (DATA_WIDTH % 8 != 0) begin : g_err_width
    $error("ddr3_mem_array: DATA_WIDTH must be a multiple of 8");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_err_latency
    $error("ddr3_mem_array: RD_LATENCY must be within 1..8");
  end
  if (OVL_BR || OVL_BC || OVL_RC) begin : g_err_overlap
    $error("ddr3_mem_array: bank/row/column fields overlap");
  end
  if (BANK_LSB + BANK_W > ADDR_WIDTH || ROW_LSB + ROW_W > ADDR_WIDTH ||
      COL_LSB + COL_W > ADDR_WIDTH) begin : g_err_range
    $error("ddr3_mem_array: address field exceeds ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_pipe_r [RD_LATENCY];
  logic [RD_LATENCY-1:0] valid_pipe_r;
  logic [IW-1:0]         widx_s;
  logic [IW-1:0]         ridx_s;
  logic                  collide_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  unused_addr_s;

  assign widx_s = {wr_addr[BANK_LSB +: BANK_W], wr_addr[ROW_LSB +: ROW_W], wr_addr[COL_LSB +: COL_W]};
  assign ridx_s = {rd_addr[BANK_LSB +: BANK_W], rd_addr[ROW_LSB +: ROW_W], rd_addr[COL_LSB +: COL_W]};
  assign collide_s = wr_en & rd_en & (widx_s == ridx_s);
  // Bits outside the three fields are deliberately ignored (aliasing).
  assign unused_addr_s = ^{wr_addr, rd_addr};

`ifdef MEM_UNINIT_CHK_EN
  logic [DEPTH-1:0]      written_r;
  logic [RD_LATENCY-1:0] uninit_pipe_r;
  logic                  rd_unwritten_s;

  // A collision write that enables any lane counts as written for this read.
  assign rd_unwritten_s = ~(written_r[ridx_s] | (collide_s & (|wr_be)));

  // Per-word written flags, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_r <= '0;
    end else if (wr_en && (|wr_be)) begin
      written_r[widx_s] <= 1'b1;
    end
  end

  // Uninit flag travels alongside the valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uninit_pipe_r <= '0;
    end else begin
      uninit_pipe_r[0] <= rd_en & rd_unwritten_s;
      for (int k = 1; k < RD_LATENCY; k++) begin
        uninit_pipe_r[k] <= uninit_pipe_r[k-1];
      end
    end
  end

  assign rd_uninit = uninit_pipe_r[RD_LATENCY-1];
`else
  assign rd_uninit = 1'b0;
`endif

  // Stage-0 read word with write-first bypass on enabled lanes.
  always_comb begin
    rd_word_s = mem_r[ridx_s];
    for (int i = 0; i < NB; i++) begin
      if (collide_s && wr_be[i]) begin
        rd_word_s[8*i +: 8] = wr_data[8*i +: 8];
      end else begin
        rd_word_s[8*i +: 8] = mem_r[ridx_s][8*i +: 8];
      end
    end
`ifdef MEM_UNINIT_CHK_EN
    if (rd_unwritten_s) begin
      rd_word_s = {DATA_WIDTH{1'bx}};
    end else begin
      rd_word_s = rd_word_s;
    end
`endif
  end

  // Byte-masked array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i]) begin
          mem_r[widx_s][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read pipeline; a stage only loads when valid data arrives, so rd_data holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pipe_r <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        data_pipe_r[k] <= '0;
      end
    end else begin
      valid_pipe_r[0] <= rd_en;
      if (rd_en) begin
        data_pipe_r[0] <= rd_word_s;
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        valid_pipe_r[k] <= valid_pipe_r[k-1];
        if (valid_pipe_r[k-1]) begin
          data_pipe_r[k] <= data_pipe_r[k-1];
        end
      end
    end
  end

  assign rd_data  = data_pipe_r[RD_LATENCY-1];
  assign rd_valid = valid_pipe_r[RD_LATENCY-1];

endmodule

// File: tb/tb_ddr3_mem_array.sv
// Directed bench for ddr3_mem_array at RD_LATENCY=3; covers MEM_UNINIT_CHK_EN when defined.
module tb_ddr3_mem_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [35:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [35:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_uninit;

  int vecs = 0;
  int errs = 0;

  ddr3_mem_array #(.RD_LATENCY(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_uninit(rd_uninit)
  );

  always #5 clk = ~clk;

  function automatic logic [35:0] mk_addr(input logic [2:0] bank, input logic [4:0] row,
                                          input logic [7:0] col);
    logic [35:0] a;
    a = '0;
    a[34:32] = bank;
    a[20:16] = row;
    a[7:0]   = col;
    return a;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [35:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    cyc();
    wr_en = 1'b0;
  endtask

  // Completes a read already driven on rd_en: checks the 3-cycle latency, data and uninit flag.
  task automatic finish_read(input string tag, input logic [15:0] exp, input logic chk_data,
                             input logic exp_uninit);
    cyc();
    rd_en = 1'b0; wr_en = 1'b0;
    chk1({tag, "_lat1"}, rd_valid, 1'b0);
    cyc();
    chk1({tag, "_lat2"}, rd_valid, 1'b0);
    cyc();
    chk1({tag, "_valid"}, rd_valid, 1'b1);
    if (chk_data) chk16({tag, "_data"}, rd_data, exp);
    chk1({tag, "_uninit"}, rd_uninit, exp_uninit);
  endtask

  task automatic do_read(input string tag, input logic [35:0] a, input logic [15:0] exp,
                         input logic chk_data, input logic exp_uninit);
    rd_en = 1'b1; rd_addr = a;
    finish_read(tag, exp, chk_data, exp_uninit);
  endtask

  initial begin
    logic [35:0] a1, a2, a3, a4;
    logic        uninit_on;
`ifdef MEM_UNINIT_CHK_EN
    uninit_on = 1'b1;
`else
    uninit_on = 1'b0;
`endif
    a1 = mk_addr(3'd2, 5'd5, 8'h10);
    a2 = mk_addr(3'd1, 5'd3, 8'h20);
    a3 = mk_addr(3'd6, 5'd12, 8'h33);
    a4 = mk_addr(3'd3, 5'd9, 8'h44);

    // Reset state
    cyc();
    chk1("rst_valid", rd_valid, 1'b0);
    chk16("rst_data", rd_data, 16'h0000);
    chk1("rst_uninit", rd_uninit, 1'b0);
    cyc();
    rst_n = 1'b1;

    // Ordered write then read
    do_write(a1, 16'hA55A, 2'b11);
    do_read("wr_rd", a1, 16'hA55A, 1'b1, 1'b0);
    chk16("hold_data", rd_data, 16'hA55A);
    cyc();
    chk1("hold_valid", rd_valid, 1'b0);
    chk16("hold_data2", rd_data, 16'hA55A);

    // Byte mask
    do_write(a2, 16'h1234, 2'b11);
    do_write(a2, 16'hABCD, 2'b01);
    do_read("bytemask", a2, 16'h12CD, 1'b1, 1'b0);

    // Collision: write-first on lane 1 only
    do_write(a3, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = a3; wr_data = 16'h2222; wr_be = 2'b10;
    rd_en = 1'b1; rd_addr = a3;
    finish_read("collide", 16'h2211, 1'b1, 1'b0);
    do_read("after_collide", a3, 16'h2211, 1'b1, 1'b0);

    // Masked no-op write
    do_write(a3, 16'hFFFF, 2'b00);
    do_read("be_zero", a3, 16'h2211, 1'b1, 1'b0);

    // Streaming 16 back-to-back reads
    for (int c = 0; c < 16; c++) begin
      do_write(mk_addr(3'd0, 5'd7, 8'(c)), 16'(c) * 16'h0101, 2'b11);
    end
    for (int c = 0; c < 18; c++) begin
      rd_en = (c < 16);
      rd_addr = mk_addr(3'd0, 5'd7, 8'(c));
      cyc();
      if (c >= 2) begin
        chk1($sformatf("stream_v%0d", c - 2), rd_valid, 1'b1);
        chk16($sformatf("stream_d%0d", c - 2), rd_data, 16'(c - 2) * 16'h0101);
      end else begin
        chk1($sformatf("stream_pre%0d", c), rd_valid, 1'b0);
      end
    end
    rd_en = 1'b0;
    cyc();
    chk1("stream_end", rd_valid, 1'b0);

    // Aliasing through bit 30, plus a never-written row
    do_write(a4 | (36'd1 << 30), 16'hBEEF, 2'b11);
    do_read("alias", a4, 16'hBEEF, 1'b1, 1'b0);
    do_read("unwritten", mk_addr(3'd0, 5'd31, 8'h00), 16'h0000, 1'b0, uninit_on);

    // Reset with a read in flight
    rd_en = 1'b1; rd_addr = a1;
    cyc();
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk1("midrst_valid", rd_valid, 1'b0);
    chk16("midrst_data", rd_data, 16'h0000);
    cyc();
    chk1("midrst_valid2", rd_valid, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk1($sformatf("post_rst_v%0d", c), rd_valid, 1'b0);
    end
    chk16("post_rst_data", rd_data, 16'h0000);

    // Array survives reset; written flags do not
    do_read("post_rst_rd", a1, 16'hA55A, !uninit_on, uninit_on);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
